// File: rtl/fib_result_fifo.sv
// fib_result_fifo: collects completed Fibonacci results from the FSM.
// Each rising edge of fib_done captures {data, order, overflow, error} into a
// small FIFO. Entries are offered to the next stage over valid/ready, and
// results that arrive while the FIFO is full are counted in a saturating
// drop counter.
module fib_result_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIB_ORDER  = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       fib_done,
  input  logic [DATA_WIDTH-1:0]      fib_data,
  input  logic [FIB_ORDER-1:0]       fib_order,
  input  logic                       fib_overflw,
  input  logic                       fib_error,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [FIB_ORDER-1:0]       res_order,
  output logic                       res_ovf,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam logic [CNT_F-1:0] DEPTH_C = CNT_F'(DEPTH);

  // One stored result; packed so a slot reads and writes as a single word.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [FIB_ORDER-1:0]  order;
    logic                  ovf;
    logic                  err;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               done_q;

  logic               cap;
  logic               pop;
  logic               push;
  logic               drop;
  entry_t             wr_entry;
  entry_t             head;

  // Edge detect on done, plus the push/pop/drop decisions for this cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cap  = 1'b0;
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (!clear) begin
      cap  = fib_done & ~done_q;
      pop  = res_valid & res_ready;
      // A pop in the same cycle frees the slot that a full FIFO would lack.
      push = cap & (~full | pop);
      drop = cap & full & ~pop;
    end
  end

  // Pack the incoming result into a storage word.
  always_comb begin
    wr_entry       = '0;
    wr_entry.data  = fib_data;
    wr_entry.order = fib_order;
    wr_entry.ovf   = fib_overflw;
    wr_entry.err   = fib_error;
  end

  // Done edge register; keeps sampling through clear so a held level
  // does not produce a second capture afterwards.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= fib_done;
  end

  // Result storage; written only on an accepted push.
  // NOTE: the storage array is reset as well, so the head outputs read 0 out
  // of reset instead of whatever the slots powered up with.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Read/write pointers, wrapping naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: up on push only, down on pop only, unchanged on both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // Saturating count of results lost to a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (clear) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Head of queue and status flags, read combinationally from storage.
  always_comb begin
    head      = mem[rd_ptr];
    res_data  = head.data;
    res_order = head.order;
    res_ovf   = head.ovf;
    res_err   = head.err;
    full      = (count == DEPTH_C);
    empty     = (count == '0);
    res_valid = ~empty;
  end

endmodule

// File: tb/tb_fib_result_fifo.sv
// Directed bench for fib_result_fifo: single result, level done, fill/drop,
// push+pop at full, flag passthrough, clear and asynchronous reset.
module tb_fib_result_fifo;

  localparam int DATA_WIDTH = 64;
  localparam int FIB_ORDER  = 16;
  localparam int DEPTH      = 8;
  localparam int CNT_W      = 16;

  logic                    clk;
  logic                    reset_n;
  logic                    clear;
  logic                    fib_done;
  logic [DATA_WIDTH-1:0]   fib_data;
  logic [FIB_ORDER-1:0]    fib_order;
  logic                    fib_overflw;
  logic                    fib_error;
  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_WIDTH-1:0]   res_data;
  logic [FIB_ORDER-1:0]    res_order;
  logic                    res_ovf;
  logic                    res_err;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
  logic [CNT_W-1:0]        drop_cnt;

  int vectors;
  int miscompares;

  fib_result_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIB_ORDER (FIB_ORDER),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .fib_done   (fib_done),
    .fib_data   (fib_data),
    .fib_order  (fib_order),
    .fib_overflw(fib_overflw),
    .fib_error  (fib_error),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_order  (res_order),
    .res_ovf    (res_ovf),
    .res_err    (res_err),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One done pulse: high for one edge (the capture), then low for one edge.
  task automatic pulse(input logic [15:0] ord, input logic [63:0] dat,
                       input logic ovf, input logic err);
    fib_done    = 1'b1;
    fib_order   = ord;
    fib_data    = dat;
    fib_overflw = ovf;
    fib_error   = err;
    step();
    fib_done    = 1'b0;
    fib_overflw = 1'b0;
    fib_error   = 1'b0;
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_empty"}, 64'(empty),     64'd1);
    check({tag, "_full"},  64'(full),      64'd0);
    check({tag, "_count"}, 64'(count),     64'd0);
    check({tag, "_drop"},  64'(drop_cnt),  64'd0);
    check({tag, "_data"},  res_data,       64'd0);
    check({tag, "_order"}, 64'(res_order), 64'd0);
    check({tag, "_flags"}, 64'({res_ovf, res_err}), 64'd0);
  endtask

  logic [63:0] fib_tab [10];
  logic [63:0] drain_data [8];
  logic [15:0] drain_order [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    clear       = 1'b0;
    fib_done    = 1'b0;
    fib_data    = '0;
    fib_order   = '0;
    fib_overflw = 1'b0;
    fib_error   = 1'b0;
    res_ready   = 1'b0;
    fib_tab     = '{64'd1, 64'd1, 64'd2, 64'd3, 64'd5, 64'd8, 64'd13, 64'd21,
                    64'd34, 64'd55};

    // Reset state.
    #12;
    check_reset_state("reset");
    reset_n = 1'b1;
    step();

    // Single result, consumer waits; no bypass before the capture edge.
    fib_done  = 1'b1;
    fib_order = 16'd10;
    fib_data  = 64'd55;
    #1;
    check("no_bypass_valid", 64'(res_valid), 64'd0);
    step();
    check("single_valid", 64'(res_valid), 64'd1);
    check("single_data",  res_data,       64'd55);
    check("single_order", 64'(res_order), 64'd10);
    check("single_count", 64'(count),     64'd1);
    fib_done  = 1'b0;
    fib_order = 16'd0;
    fib_data  = 64'd0;
    step();
    step();
    check("single_hold_data",  res_data,       64'd55);
    check("single_hold_order", 64'(res_order), 64'd10);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("single_pop_empty", 64'(empty),     64'd1);
    check("single_pop_valid", 64'(res_valid), 64'd0);

    // Ready while empty is ignored.
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("ready_empty_count", 64'(count), 64'd0);

    // Level done held for five cycles gives one capture.
    fib_done  = 1'b1;
    fib_order = 16'd7;
    fib_data  = 64'd13;
    for (int i = 0; i < 5; i++) step();
    check("level_count", 64'(count), 64'd1);
    fib_done = 1'b0;
    step();
    check("level_count_after", 64'(count), 64'd1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("level_drained", 64'(empty), 64'd1);

    // Fill with orders 1..10; the last two are dropped.
    for (int n = 1; n <= 10; n++) begin
      pulse(16'(n), fib_tab[n-1], 1'b0, 1'b0);
      if (n == 8) begin
        check("fill8_full",  64'(full),  64'd1);
        check("fill8_count", 64'(count), 64'd8);
        check("fill8_drop",  64'(drop_cnt), 64'd0);
      end
    end
    check("fill10_drop",  64'(drop_cnt), 64'd2);
    check("fill10_count", 64'(count),    64'd8);
    check("fill_head_order", 64'(res_order), 64'd1);
    check("fill_head_data",  res_data,       64'd1);

    // Capture and pop in the same cycle while full: accepted, no drop.
    fib_done  = 1'b1;
    fib_order = 16'd11;
    fib_data  = 64'd89;
    res_ready = 1'b1;
    step();
    fib_done  = 1'b0;
    res_ready = 1'b0;
    check("pushpop_count", 64'(count),    64'd8);
    check("pushpop_drop",  64'(drop_cnt), 64'd2);
    check("pushpop_full",  64'(full),     64'd1);
    step();

    // Drain: orders 2..8 then the late entry 11.
    drain_order = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd11};
    drain_data  = '{64'd1, 64'd2, 64'd3, 64'd5, 64'd8, 64'd13, 64'd21, 64'd89};
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_valid", i), 64'(res_valid), 64'd1);
      check($sformatf("drain%0d_order", i), 64'(res_order), 64'(drain_order[i]));
      check($sformatf("drain%0d_data", i),  res_data,       drain_data[i]);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end
    check("drain_empty", 64'(empty), 64'd1);

    // Flags stored exactly as received.
    pulse(16'd94, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0);
    pulse(16'd95, 64'h0000_0000_0000_1234, 1'b0, 1'b1);
    check("flag0_order", 64'(res_order), 64'd94);
    check("flag0_ovf",   64'(res_ovf),   64'd1);
    check("flag0_err",   64'(res_err),   64'd0);
    check("flag0_data",  res_data,       64'hDEAD_BEEF_0000_0001);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("flag1_order", 64'(res_order), 64'd95);
    check("flag1_ovf",   64'(res_ovf),   64'd0);
    check("flag1_err",   64'(res_err),   64'd1);
    check("flag1_data",  res_data,       64'h1234);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("flag_empty", 64'(empty), 64'd1);

    // Clear with three entries, a capture and a pop in the same cycle.
    for (int n = 1; n <= 3; n++) pulse(16'(20 + n), 64'(n), 1'b0, 1'b0);
    check("preclear_count", 64'(count),    64'd3);
    check("preclear_drop",  64'(drop_cnt), 64'd2);
    clear     = 1'b1;
    fib_done  = 1'b1;
    fib_order = 16'd30;
    fib_data  = 64'd77;
    res_ready = 1'b1;
    step();
    clear     = 1'b0;
    res_ready = 1'b0;
    check("clear_count", 64'(count),     64'd0);
    check("clear_drop",  64'(drop_cnt),  64'd0);
    check("clear_valid", 64'(res_valid), 64'd0);
    step();
    check("clear_held_done", 64'(count), 64'd0);
    fib_done = 1'b0;
    step();

    // Asynchronous reset in the middle of a drain.
    for (int n = 1; n <= 3; n++) pulse(16'(40 + n), 64'(100 + n), 1'b1, 1'b1);
    res_ready = 1'b1;
    step();
    check("middrain_order", 64'(res_order), 64'd42);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    res_ready = 1'b0;
    #3;
    reset_n = 1'b1;
    step();
    check("post_reset_empty", 64'(empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
